// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states, byte-lane geometry.
package mem_access_pkg;

   localparam int BYTE_LANES = 4;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: byte enables, replicated store lanes and extended load data.
// Half/word offsets are forced aligned here; misalignment policy is decided by the caller.
module mem_lane_align
   import mem_access_pkg::*;
#(
   parameter int DATA_W = BYTE_LANES * 8
) (
   input  logic [1:0]          size,
   input  logic [1:0]          addr_lo,
   input  logic                is_unsigned,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W-1:0]   rword,
   output logic [DATA_W/8-1:0] byte_en,
   output logic [DATA_W-1:0]   lane_wdata,
   output logic [DATA_W-1:0]   load_data
);

   localparam int LANES = DATA_W / 8;

   logic [1:0]        off_s;
   logic [DATA_W-1:0] shifted_s;

   // Effective byte offset of the access within the word.
   always_comb begin
      off_s = 2'b00;
      case (size)
         SZ_BYTE: off_s = addr_lo;
         SZ_HALF: off_s = {addr_lo[1], 1'b0};
         default: off_s = 2'b00;
      endcase
   end

   assign shifted_s = rword >> {off_s, 3'b000};

   // Lane enables, store replication and load extension per size.
   always_comb begin
      byte_en    = {LANES{1'b0}};
      lane_wdata = wdata;
      load_data  = rword;
      case (size)
         SZ_BYTE: begin
            byte_en    = {{(LANES-1){1'b0}}, 1'b1} << off_s;
            lane_wdata = {LANES{wdata[7:0]}};
            load_data  = {{(DATA_W-8){shifted_s[7] & ~is_unsigned}}, shifted_s[7:0]};
         end
         SZ_HALF: begin
            byte_en    = {{(LANES-2){1'b0}}, 2'b11} << off_s;
            lane_wdata = {(LANES/2){wdata[15:0]}};
            load_data  = {{(DATA_W-16){shifted_s[15] & ~is_unsigned}}, shifted_s[15:0]};
         end
         default: begin
            byte_en    = {LANES{1'b1}};
            lane_wdata = wdata;
            load_data  = rword;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// Multi-cycle MEM stage with wait states, byte-lane alignment and ALU passthrough.
// Optional misaligned-access trapping is enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_stage
   import mem_access_pkg::*;
#(
   parameter int DATA_W      = BYTE_LANES * 8,
   parameter int ADDR_W      = 7,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_valid,
   input  logic              i_wr_mem,
   input  logic              i_mem_to_reg,
   input  logic              i_is_unsigned,
   input  logic [1:0]        i_size,
   input  logic [DATA_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_debug_addr,
   output logic [DATA_W-1:0] o_debug_data,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   output logic              o_stall,
   output logic              o_misaligned
);

   localparam int         LANES    = DATA_W / 8;
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   logic [DATA_W-1:0] mem_r [0:(2**ADDR_W)-1];

   state_e            state_r;
   logic [3:0]        cnt_r;
   logic              wr_r, m2r_r, uns_r, valid_r, mis_r;
   logic [1:0]        size_r;
   logic [DATA_W-1:0] addr_r, wdata_r, resp_data_r;

   logic              cur_wr_s, cur_m2r_s, cur_uns_s, mis_s;
   logic [1:0]        cur_size_s;
   logic [DATA_W-1:0] cur_addr_s, cur_wdata_s, resp_s;
   logic [ADDR_W-1:0] idx_s;
   logic [LANES-1:0]  be_s;
   logic [DATA_W-1:0] lane_wdata_s, load_data_s;
   logic              accept_s, enter_resp_s, do_write_s;

   // With zero wait states the access completes on the acceptance edge, so use live inputs in IDLE.
   always_comb begin
      if (state_r == ST_IDLE) begin
         cur_wr_s    = i_wr_mem;
         cur_m2r_s   = i_mem_to_reg;
         cur_uns_s   = i_is_unsigned;
         cur_size_s  = i_size;
         cur_addr_s  = i_addr;
         cur_wdata_s = i_wdata;
      end else begin
         cur_wr_s    = wr_r;
         cur_m2r_s   = m2r_r;
         cur_uns_s   = uns_r;
         cur_size_s  = size_r;
         cur_addr_s  = addr_r;
         cur_wdata_s = wdata_r;
      end
   end

   assign idx_s = cur_addr_s[ADDR_W+1:2];

   mem_lane_align #(.DATA_W(DATA_W)) u_align (
      .size        (cur_size_s),
      .addr_lo     (cur_addr_s[1:0]),
      .is_unsigned (cur_uns_s),
      .wdata       (cur_wdata_s),
      .rword       (mem_r[idx_s]),
      .byte_en     (be_s),
      .lane_wdata  (lane_wdata_s),
      .load_data   (load_data_s)
   );

   // Misalignment classification of the current request.
   always_comb begin
      mis_s = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      case (cur_size_s)
         SZ_BYTE: mis_s = 1'b0;
         SZ_HALF: mis_s = cur_addr_s[0];
         default: mis_s = (cur_addr_s[1:0] != 2'b00);
      endcase
`endif
   end

   assign accept_s     = (state_r == ST_IDLE) && i_valid;
   assign enter_resp_s = (accept_s && (WAIT_CYCLES == 0)) ||
                         ((state_r == ST_WAIT) && (cnt_r == 4'd0));
   assign do_write_s   = enter_resp_s && !i_reset && cur_wr_s && !mis_s;

   // Response value captured on the edge entering RESP.
   always_comb begin
      if (mis_s && !cur_wr_s) begin
         resp_s = {DATA_W{1'b0}};
      end else if (cur_m2r_s) begin
         resp_s = load_data_s;
      end else begin
         resp_s = cur_addr_s;
      end
   end

   // Control FSM, wait counter and latched request.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 4'd0;
         wr_r        <= 1'b0;
         m2r_r       <= 1'b0;
         uns_r       <= 1'b0;
         size_r      <= 2'b00;
         addr_r      <= {DATA_W{1'b0}};
         wdata_r     <= {DATA_W{1'b0}};
         resp_data_r <= {DATA_W{1'b0}};
         valid_r     <= 1'b0;
         mis_r       <= 1'b0;
      end else begin
         valid_r <= enter_resp_s;
         mis_r   <= enter_resp_s && mis_s;
         if (enter_resp_s) begin
            resp_data_r <= resp_s;
         end
         case (state_r)
            ST_IDLE: begin
               if (i_valid) begin
                  wr_r    <= i_wr_mem;
                  m2r_r   <= i_mem_to_reg;
                  uns_r   <= i_is_unsigned;
                  size_r  <= i_size;
                  addr_r  <= i_addr;
                  wdata_r <= i_wdata;
                  cnt_r   <= CNT_INIT;
                  state_r <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
               end
            end
            ST_WAIT: begin
               if (cnt_r == 4'd0) begin
                  state_r <= ST_RESP;
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            ST_RESP: state_r <= ST_IDLE;
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   // Byte-masked memory write; contents survive reset.
   always_ff @(posedge i_clk) begin
      for (int l = 0; l < LANES; l++) begin
         if (do_write_s && be_s[l]) begin
            mem_r[idx_s][8*l +: 8] <= lane_wdata_s[8*l +: 8];
         end
      end
   end

   assign o_debug_data = mem_r[i_debug_addr];
   assign o_data       = (state_r == ST_RESP) ? resp_data_r : i_addr;
   assign o_valid      = valid_r;
   assign o_stall      = accept_s || (state_r == ST_WAIT);
   assign o_misaligned = mis_r;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against a byte-array reference model.
module tb_mem_access_stage;

   localparam int DW = 32;
   localparam int AW = 7;
   localparam int WC = 2;
`ifdef MEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          i_reset, i_valid, i_wr_mem, i_mem_to_reg, i_is_unsigned;
   logic [1:0]    i_size;
   logic [DW-1:0] i_addr, i_wdata;
   logic [AW-1:0] i_debug_addr;
   logic [DW-1:0] o_debug_data, o_data;
   logic          o_valid, o_stall, o_misaligned;

   int n_vec = 0;
   int n_bad = 0;

   logic [7:0] mb [0:(4<<AW)-1];

   mem_access_stage #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_wr_mem(i_wr_mem),
      .i_mem_to_reg(i_mem_to_reg), .i_is_unsigned(i_is_unsigned), .i_size(i_size),
      .i_addr(i_addr), .i_wdata(i_wdata), .i_debug_addr(i_debug_addr),
      .o_debug_data(o_debug_data), .o_data(o_data), .o_valid(o_valid),
      .o_stall(o_stall), .o_misaligned(o_misaligned)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit is_mis(input logic [1:0] sz, input logic [31:0] a);
      if (!TRAP) return 1'b0;
      if (sz == 2'b01) return a[0];
      if (sz[1]) return (a % 4) != 0;
      return 1'b0;
   endfunction

   function automatic int unsigned base_byte(input logic [1:0] sz, input logic [31:0] a);
      int unsigned w, off;
      w   = (a / 4) % (1 << AW);
      off = a % 4;
      if (sz == 2'b01) off = (off / 2) * 2;
      else if (sz[1]) off = 0;
      return w * 4 + off;
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] sz, input logic [31:0] a, input bit uns);
      int unsigned b;
      int v;
      b = base_byte(sz, a);
      if (sz == 2'b00) begin
         v = int'(mb[b]);
         if (!uns && v > 127) v -= 256;
         return 32'(v);
      end else if (sz == 2'b01) begin
         v = int'(mb[b]) + 256 * int'(mb[b+1]);
         if (!uns && v > 32767) v -= 65536;
         return 32'(v);
      end
      return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
   endfunction

   task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      int unsigned b, n;
      logic [31:0] d;
      b = base_byte(sz, a);
      n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      d = wd;
      for (int i = 0; i < int'(n); i++) begin
         mb[b+i] = d[7:0];
         d = d >> 8;
      end
   endtask

   task automatic access(input bit wr, input bit m2r, input bit uns, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd, input string tag,
                         output logic [31:0] got);
      int cyc, stalls;
      bit seen, mis;
      logic [31:0] exp;
      mis = is_mis(sz, a);
      exp = wr ? a : (mis ? 32'h0 : (m2r ? model_load(sz, a, uns) : a));
      @(negedge clk);
      i_valid = 1'b1; i_wr_mem = wr; i_mem_to_reg = m2r; i_is_unsigned = uns;
      i_size = sz; i_addr = a; i_wdata = wd;
      #1 stalls = int'(o_stall);
      cyc = 0; seen = 1'b0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (o_valid) seen = 1'b1;
         else stalls += int'(o_stall);
      end
      got = o_data;
      check_eq({tag, "_lat"}, cyc, WC + 1);
      check_eq({tag, "_stall"}, stalls, WC + 1);
      check_eq({tag, "_data"}, o_data, exp);
      check_eq({tag, "_mis"}, {31'd0, o_misaligned}, {31'd0, mis});
      i_valid = 1'b0;
      if (wr && !mis) model_store(sz, a, wd);
      #1 check_eq({tag, "_resp_stall"}, {31'd0, o_stall}, 32'd0);
      @(negedge clk);
      check_eq({tag, "_pulse"}, {31'd0, o_valid}, 32'd0);
      check_eq({tag, "_pass"}, o_data, a);
   endtask

   initial begin
      logic [31:0] got, old4, a;
      bit wr, any_valid;
      logic [1:0] sz;

      i_reset = 1'b1; i_valid = 1'b0; i_wr_mem = 1'b0; i_mem_to_reg = 1'b0;
      i_is_unsigned = 1'b0; i_size = 2'b00; i_addr = 32'h0; i_wdata = 32'h0; i_debug_addr = '0;
      repeat (3) @(negedge clk);
      i_reset = 1'b0;
      #1;
      check_eq("rst_valid", {31'd0, o_valid}, 32'd0);
      check_eq("rst_mis", {31'd0, o_misaligned}, 32'd0);
      check_eq("rst_stall", {31'd0, o_stall}, 32'd0);

      for (int w = 0; w < (1 << AW); w++) access(1'b1, 1'b0, 1'b0, 2'b10, 32'(w * 4), $urandom, "fill", got);

      access(1'b1, 1'b0, 1'b0, 2'b10, 32'h10, 32'hDEADBEEF, "w_st", got);
      access(1'b0, 1'b1, 1'b0, 2'b10, 32'h10, 32'h0, "w_ld", got);
      check_eq("w_ld_const", got, 32'hDEADBEEF);

      access(1'b1, 1'b0, 1'b0, 2'b10, 32'h20, 32'h0, "b_clr", got);
      access(1'b1, 1'b0, 1'b0, 2'b00, 32'h23, 32'h80, "b_st", got);
      access(1'b0, 1'b1, 1'b0, 2'b10, 32'h20, 32'h0, "b_ldw", got);
      check_eq("b_ldw_const", got, 32'h80000000);
      access(1'b0, 1'b1, 1'b0, 2'b00, 32'h23, 32'h0, "b_lds", got);
      check_eq("b_lds_const", got, 32'hFFFFFF80);
      access(1'b0, 1'b1, 1'b1, 2'b00, 32'h23, 32'h0, "b_ldu", got);
      check_eq("b_ldu_const", got, 32'h00000080);

      access(1'b1, 1'b0, 1'b0, 2'b10, 32'h40, 32'h12345678, "h_init", got);
      access(1'b1, 1'b0, 1'b0, 2'b01, 32'h42, 32'h0000BEEF, "h_st", got);
      access(1'b0, 1'b1, 1'b0, 2'b01, 32'h42, 32'h0, "h_lds", got);
      check_eq("h_lds_const", got, 32'hFFFFBEEF);
      access(1'b0, 1'b1, 1'b0, 2'b10, 32'h40, 32'h0, "h_ldw", got);
      check_eq("h_ldw_const", got, 32'hBEEF5678);

      @(negedge clk);
      i_valid = 1'b0; i_addr = 32'h1234;
      #1;
      check_eq("pass_data", o_data, 32'h1234);
      check_eq("pass_stall", {31'd0, o_stall}, 32'd0);
      check_eq("pass_valid", {31'd0, o_valid}, 32'd0);

      access(1'b1, 1'b0, 1'b0, 2'b10, 32'h8, 32'h11111111, "rw_init", got);
      @(negedge clk);
      i_valid = 1'b1; i_wr_mem = 1'b1; i_mem_to_reg = 1'b0; i_size = 2'b10;
      i_addr = 32'h8; i_wdata = 32'h55555555;
      @(negedge clk);
      any_valid = o_valid;
      i_valid = 1'b0; i_reset = 1'b1;
      @(negedge clk);
      any_valid |= o_valid;
      i_reset = 1'b0; i_addr = 32'h77;
      #1;
      check_eq("rw_idle_stall", {31'd0, o_stall}, 32'd0);
      check_eq("rw_idle_pass", o_data, 32'h77);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         any_valid |= o_valid;
      end
      check_eq("rw_no_valid", {31'd0, any_valid}, 32'd0);
      access(1'b0, 1'b1, 1'b0, 2'b10, 32'h8, 32'h0, "rw_ld", got);
      check_eq("rw_ld_const", got, 32'h11111111);

      old4 = model_load(2'b10, 32'h4, 1'b0);
      access(1'b1, 1'b0, 1'b0, 2'b10, 32'h6, 32'hA5A5A5A5, "mis_st", got);
      access(1'b0, 1'b1, 1'b0, 2'b10, 32'h4, 32'h0, "mis_ld", got);
      check_eq("mis_word4", got, TRAP ? old4 : 32'hA5A5A5A5);

      for (int n = 0; n < 300; n++) begin
         wr = ($urandom % 2) == 1;
         sz = 2'($urandom % 4);
         a  = $urandom;
         access(wr, wr ? 1'b0 : (($urandom % 4) != 0), 1'($urandom % 2), sz, a, $urandom, "rnd", got);
         if (($urandom % 4) == 0) begin
            @(negedge clk);
            i_addr = $urandom;
            #1 check_eq("rnd_pass", o_data, i_addr);
         end
      end

      for (int w = 0; w < (1 << AW); w++) begin
         @(negedge clk);
         i_debug_addr = AW'(w);
         #1 check_eq("dbg", o_debug_data, model_load(2'b10, 32'(w * 4), 1'b0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
